// File: rtl/prim_subreg_shadow_bank_pkg.sv
// Shared helpers for the shadowed register bank: confirm-count sizing and
// the legal range of confirmation depths.
package prim_subreg_shadow_bank_pkg;

  localparam int MaxConfirm = 4;
  localparam int MinConfirm = 2;

  // Width of the confirm counter, which runs 0..num_confirm-1.
  function automatic int cnt_width(input int num_confirm);
    return (num_confirm <= 2) ? 1 : $clog2(num_confirm);
  endfunction

  function automatic bit confirm_ok(input int num_confirm);
    return (num_confirm >= MinConfirm) && (num_confirm <= MaxConfirm);
  endfunction

endpackage

// File: rtl/prim_subreg_shadow_bank_entry.sv
// One shadowed entry: staged/shadow/committed copies, confirm counter,
// and registered commit / update-error / storage-error outputs.
module prim_subreg_shadow_bank_entry
  import prim_subreg_shadow_bank_pkg::*;
#(
  parameter int             DW         = 32,
  parameter int             NumConfirm = 2,
  parameter logic [DW-1:0]  RESVAL     = '0
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          we_i,
  input  logic          re_i,
  input  logic          abort_i,
  input  logic [DW-1:0] wd_i,
  output logic [DW-1:0] q_o,
  output logic          qe_o,
  output logic          phase_o,
  output logic          err_update_o,
  output logic          err_storage_o
);

  localparam int            CW      = cnt_width(NumConfirm);
  localparam logic [CW-1:0] LastCnt = CW'(NumConfirm - 1);

  logic [DW-1:0] staged_q, staged_d;
  logic [DW-1:0] shadow_q, shadow_d;
  logic [DW-1:0] committed_q, committed_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          qe_q, qe_d;
  logic          err_update_q, err_update_d;
  logic          err_storage_q, err_storage_d;

  // NOTE: every signal gets a default before any branch, otherwise the
  // incomplete paths would infer latches.
  always_comb begin
    staged_d      = staged_q;
    shadow_d      = shadow_q;
    committed_d   = committed_q;
    cnt_d         = cnt_q;
    qe_d          = 1'b0;
    err_update_d  = 1'b0;
    err_storage_d = err_storage_q | (~shadow_q != committed_q);

    if (err_storage_q) begin
      cnt_d = '0;
    end else if (we_i) begin
      if (cnt_q == '0) begin
        staged_d = ~wd_i;
        cnt_d    = CW'(1);
      end else if (wd_i == ~staged_q) begin
        if (cnt_q == LastCnt) begin
          committed_d = wd_i;
          shadow_d    = ~wd_i;
          cnt_d       = '0;
          qe_d        = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end else begin
        err_update_d = 1'b1;
        cnt_d        = '0;
      end
    end else if (re_i || abort_i) begin
      cnt_d = '0;
    end
  end

  // NOTE: state flops use non-blocking assignments so all entries update
  // from the same pre-edge values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      staged_q      <= ~RESVAL;
      shadow_q      <= ~RESVAL;
      committed_q   <= RESVAL;
      cnt_q         <= '0;
      qe_q          <= 1'b0;
      err_update_q  <= 1'b0;
      err_storage_q <= 1'b0;
    end else begin
      staged_q      <= staged_d;
      shadow_q      <= shadow_d;
      committed_q   <= committed_d;
      cnt_q         <= cnt_d;
      qe_q          <= qe_d;
      err_update_q  <= err_update_d;
      err_storage_q <= err_storage_d;
    end
  end

  assign q_o           = committed_q;
  assign qe_o          = qe_q;
  assign phase_o       = (cnt_q != '0);
  assign err_update_o  = err_update_q;
  assign err_storage_o = err_storage_q;

endmodule

// File: rtl/prim_subreg_shadow_bank.sv
// Bank of shadowed control registers behind one software write port; the
// address decode turns each access into per-entry write/read/abort strobes.
module prim_subreg_shadow_bank
  import prim_subreg_shadow_bank_pkg::*;
#(
  parameter int             DW         = 32,
  parameter int             NumRegs    = 4,
  parameter int             NumConfirm = 2,
  parameter logic [DW-1:0]  RESVAL     = '0,
  localparam int            AW         = (NumRegs > 1) ? $clog2(NumRegs) : 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  we_i,
  input  logic                  re_i,
  input  logic [AW-1:0]         addr_i,
  input  logic [DW-1:0]         wd_i,
  output logic [DW-1:0]         rdata_o,
  output logic [NumRegs*DW-1:0] q_o,
  output logic [NumRegs-1:0]    qe_o,
  output logic [NumRegs-1:0]    phase_o,
  output logic [NumRegs-1:0]    err_update_o,
  output logic [NumRegs-1:0]    err_storage_o
);

  if (!confirm_ok(NumConfirm)) begin : gen_bad_confirm
    $error("prim_subreg_shadow_bank: NumConfirm must be in %0d..%0d", MinConfirm, MaxConfirm);
  end
  if (NumRegs < 1) begin : gen_bad_numregs
    $error("prim_subreg_shadow_bank: NumRegs must be at least 1");
  end

  logic [DW-1:0] q [NumRegs];

  for (genvar i = 0; i < NumRegs; i++) begin : gen_entry
    logic sel;
    // An access anywhere else, including out of range, aborts this entry.
    assign sel = (addr_i == AW'(i));

    prim_subreg_shadow_bank_entry #(
      .DW         (DW),
      .NumConfirm (NumConfirm),
      .RESVAL     (RESVAL)
    ) u_entry (
      .clk_i         (clk_i),
      .rst_ni        (rst_ni),
      .we_i          (we_i & sel),
      .re_i          (re_i & ~we_i & sel),
      .abort_i       ((we_i | re_i) & ~sel),
      .wd_i          (wd_i),
      .q_o           (q[i]),
      .qe_o          (qe_o[i]),
      .phase_o       (phase_o[i]),
      .err_update_o  (err_update_o[i]),
      .err_storage_o (err_storage_o[i])
    );

    assign q_o[i*DW +: DW] = q[i];
  end

  always_comb begin
    rdata_o = '0;
    for (int i = 0; i < NumRegs; i++) begin
      if (addr_i == AW'(i)) rdata_o = q[i];
    end
  end

endmodule

// File: tb/tb_prim_subreg_shadow_bank.sv
// Directed bench for the shadowed register bank: three instances share one
// stimulus bus (2-confirm/4 entries, 3-confirm with nonzero reset, 3 entries).
module tb_prim_subreg_shadow_bank;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        we = 1'b0;
  logic        re = 1'b0;
  logic [1:0]  addr = '0;
  logic [31:0] wd = '0;

  logic [31:0]  rdata_a, rdata_b, rdata_c;
  logic [127:0] q_a, q_b;
  logic [95:0]  q_c;
  logic [3:0]   qe_a, ph_a, eu_a, es_a;
  logic [3:0]   qe_b, ph_b, eu_b, es_b;
  logic [2:0]   qe_c, ph_c, eu_c, es_c;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  prim_subreg_shadow_bank #(.DW(32), .NumRegs(4), .NumConfirm(2)) dut_a (
    .clk_i(clk), .rst_ni(rst_n), .we_i(we), .re_i(re), .addr_i(addr), .wd_i(wd),
    .rdata_o(rdata_a), .q_o(q_a), .qe_o(qe_a), .phase_o(ph_a),
    .err_update_o(eu_a), .err_storage_o(es_a));

  prim_subreg_shadow_bank #(.DW(32), .NumRegs(4), .NumConfirm(3), .RESVAL(32'h0000_00FF)) dut_b (
    .clk_i(clk), .rst_ni(rst_n), .we_i(we), .re_i(re), .addr_i(addr), .wd_i(wd),
    .rdata_o(rdata_b), .q_o(q_b), .qe_o(qe_b), .phase_o(ph_b),
    .err_update_o(eu_b), .err_storage_o(es_b));

  prim_subreg_shadow_bank #(.DW(32), .NumRegs(3), .NumConfirm(2)) dut_c (
    .clk_i(clk), .rst_ni(rst_n), .we_i(we), .re_i(re), .addr_i(addr), .wd_i(wd),
    .rdata_o(rdata_c), .q_o(q_c), .qe_o(qe_c), .phase_o(ph_c),
    .err_update_o(eu_c), .err_storage_o(es_c));

  task automatic apply_reset();
    we = 1'b0; re = 1'b0; addr = '0; wd = '0;
    @(negedge clk) rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    we = 1'b1; re = 1'b0; addr = a; wd = d;
    @(posedge clk); #1;
    we = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a);
    re = 1'b1; we = 1'b0; addr = a;
    @(posedge clk); #1;
    re = 1'b0;
  endtask

  task automatic idle();
    we = 1'b0; re = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    apply_reset();
    #1;
    n_checks++; if (q_a !== 128'h0) begin n_fail++; $display("FAIL reset_q_a: got %h expected 0", q_a); end
    n_checks++; if ({qe_a, ph_a, eu_a, es_a} !== 16'h0) begin n_fail++; $display("FAIL reset_flags_a: got %h expected 0", {qe_a, ph_a, eu_a, es_a}); end
    n_checks++; if (q_b !== {4{32'h0000_00FF}}) begin n_fail++; $display("FAIL reset_q_b: got %h expected %h", q_b, {4{32'h0000_00FF}}); end
    addr = 2'd2; #1;
    n_checks++; if (rdata_b !== 32'h0000_00FF) begin n_fail++; $display("FAIL reset_rdata_b: got %h expected 000000ff", rdata_b); end
    addr = 2'd3; #1;
    n_checks++; if (rdata_c !== 32'h0) begin n_fail++; $display("FAIL rdata_out_of_range: got %h expected 0", rdata_c); end
  endtask

  task automatic test_commit();
    apply_reset();
    wr(2'd1, 32'hA5A5_0001);
    n_checks++; if (ph_a !== 4'b0010) begin n_fail++; $display("FAIL commit_phase1: got %b expected 0010", ph_a); end
    n_checks++; if (qe_a !== 4'b0000) begin n_fail++; $display("FAIL commit_early_qe: got %b expected 0000", qe_a); end
    wr(2'd1, 32'hA5A5_0001);
    n_checks++; if (qe_a !== 4'b0010) begin n_fail++; $display("FAIL commit_qe: got %b expected 0010", qe_a); end
    n_checks++; if (q_a !== 128'h0000_0000_0000_0000_A5A5_0001_0000_0000) begin n_fail++; $display("FAIL commit_q: got %h", q_a); end
    n_checks++; if (ph_a !== 4'b0000) begin n_fail++; $display("FAIL commit_phase_clear: got %b expected 0000", ph_a); end
    addr = 2'd1;
    idle();
    n_checks++; if (qe_a !== 4'b0000) begin n_fail++; $display("FAIL commit_qe_oneshot: got %b expected 0000", qe_a); end
    n_checks++; if (rdata_a !== 32'hA5A5_0001) begin n_fail++; $display("FAIL commit_rdata: got %h expected a5a50001", rdata_a); end
  endtask

  task automatic test_mismatch();
    apply_reset();
    wr(2'd0, 32'h11);
    wr(2'd0, 32'h11);
    n_checks++; if (ph_b[0] !== 1'b1 || eu_b !== 4'b0000) begin n_fail++; $display("FAIL mm_mid: phase %b err %b expected 1/0000", ph_b[0], eu_b); end
    wr(2'd0, 32'h12);
    n_checks++; if (eu_b !== 4'b0001) begin n_fail++; $display("FAIL mm_err: got %b expected 0001", eu_b); end
    n_checks++; if (q_b[31:0] !== 32'h0000_00FF || qe_b !== 4'b0) begin n_fail++; $display("FAIL mm_q: got %h qe %b expected 000000ff/0", q_b[31:0], qe_b); end
    n_checks++; if (ph_b[0] !== 1'b0) begin n_fail++; $display("FAIL mm_phase: got %b expected 0", ph_b[0]); end
    idle();
    n_checks++; if (eu_b !== 4'b0000) begin n_fail++; $display("FAIL mm_err_oneshot: got %b expected 0000", eu_b); end
    wr(2'd0, 32'h33);
    wr(2'd0, 32'h33);
    n_checks++; if (qe_b !== 4'b0000) begin n_fail++; $display("FAIL c3_no_early_commit: got %b expected 0000", qe_b); end
    wr(2'd0, 32'h33);
    n_checks++; if (qe_b !== 4'b0001 || q_b[31:0] !== 32'h33) begin n_fail++; $display("FAIL c3_commit: qe %b q %h expected 0001/33", qe_b, q_b[31:0]); end
  endtask

  task automatic test_abort();
    apply_reset();
    wr(2'd2, 32'h5);
    rd(2'd3);
    n_checks++; if (ph_a[2] !== 1'b0) begin n_fail++; $display("FAIL abort_phase: got %b expected 0", ph_a[2]); end
    wr(2'd2, 32'h5);
    n_checks++; if (ph_a[2] !== 1'b1 || qe_a !== 4'b0 || eu_a !== 4'b0) begin n_fail++; $display("FAIL abort_restart: ph %b qe %b err %b expected 1/0/0", ph_a[2], qe_a, eu_a); end
    rd(2'd2);
    n_checks++; if (ph_a[2] !== 1'b0 || eu_a !== 4'b0) begin n_fail++; $display("FAIL read_own_clears: ph %b err %b expected 0/0", ph_a[2], eu_a); end
  endtask

  task automatic test_precedence();
    apply_reset();
    wr(2'd3, 32'h7);
    we = 1'b1; re = 1'b1; addr = 2'd3; wd = 32'h7;
    @(posedge clk); #1;
    we = 1'b0; re = 1'b0;
    n_checks++; if (qe_a !== 4'b1000 || q_a[96 +: 32] !== 32'h7) begin n_fail++; $display("FAIL we_re_precedence: qe %b q %h expected 1000/7", qe_a, q_a[96 +: 32]); end
  endtask

  task automatic test_out_of_range();
    apply_reset();
    wr(2'd2, 32'h9);
    n_checks++; if (ph_c !== 3'b100) begin n_fail++; $display("FAIL oor_setup: got %b expected 100", ph_c); end
    wr(2'd3, 32'h9);
    n_checks++; if (ph_c !== 3'b000 || qe_c !== 3'b000 || eu_c !== 3'b000) begin n_fail++; $display("FAIL oor_write: ph %b qe %b err %b expected 0", ph_c, qe_c, eu_c); end
    wr(2'd3, 32'h9);
    n_checks++; if (qe_c !== 3'b000 || q_c !== 96'h0) begin n_fail++; $display("FAIL oor_no_commit: qe %b q %h expected 0", qe_c, q_c); end
  endtask

  task automatic test_storage_fault();
    apply_reset();
    force dut_a.gen_entry[0].u_entry.shadow_q = 32'hFFFF_FFFE;
    @(posedge clk); #1;
    n_checks++; if (es_a !== 4'b0001) begin n_fail++; $display("FAIL storage_flag: got %b expected 0001", es_a); end
    release dut_a.gen_entry[0].u_entry.shadow_q;
    idle();
    n_checks++; if (es_a !== 4'b0001) begin n_fail++; $display("FAIL storage_sticky: got %b expected 0001", es_a); end
    wr(2'd0, 32'h55);
    n_checks++; if (ph_a[0] !== 1'b0) begin n_fail++; $display("FAIL storage_phase: got %b expected 0", ph_a[0]); end
    wr(2'd0, 32'h55);
    n_checks++; if (qe_a !== 4'b0 || q_a[31:0] !== 32'h0) begin n_fail++; $display("FAIL storage_blocked: qe %b q %h expected 0/0", qe_a, q_a[31:0]); end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    wr(2'd2, 32'h77);
    wr(2'd2, 32'h77);
    wr(2'd1, 32'hAB);
    n_checks++; if (q_a[64 +: 32] !== 32'h77 || ph_a !== 4'b0010) begin n_fail++; $display("FAIL rst_mid_setup: q %h ph %b expected 77/0010", q_a[64 +: 32], ph_a); end
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (q_a !== 128'h0 || {qe_a, ph_a, eu_a, es_a} !== 16'h0) begin n_fail++; $display("FAIL rst_async: q %h flags %h expected 0", q_a, {qe_a, ph_a, eu_a, es_a}); end
    @(negedge clk) rst_n = 1'b1;
    wr(2'd1, 32'hAB);
    n_checks++; if (qe_a !== 4'b0 || ph_a !== 4'b0010 || q_a !== 128'h0) begin n_fail++; $display("FAIL rst_first_write: qe %b ph %b expected 0/0010", qe_a, ph_a); end
  endtask

  task automatic test_back_to_back();
    apply_reset();
    wr(2'd0, 32'h1);
    wr(2'd0, 32'h1);
    n_checks++; if (qe_a !== 4'b0001 || q_a[31:0] !== 32'h1) begin n_fail++; $display("FAIL b2b_first: qe %b q %h expected 0001/1", qe_a, q_a[31:0]); end
    wr(2'd0, 32'h2);
    n_checks++; if (qe_a !== 4'b0000 || ph_a[0] !== 1'b1) begin n_fail++; $display("FAIL b2b_stage: qe %b ph %b expected 0000/1", qe_a, ph_a[0]); end
    wr(2'd0, 32'h2);
    n_checks++; if (qe_a !== 4'b0001 || q_a[31:0] !== 32'h2) begin n_fail++; $display("FAIL b2b_second: qe %b q %h expected 0001/2", qe_a, q_a[31:0]); end
  endtask

  initial begin
    test_reset();
    test_commit();
    test_mismatch();
    test_abort();
    test_precedence();
    test_out_of_range();
    test_storage_fault();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
